// File: rtl/top_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read at a time
// and hands each returned word to decode over a valid/ready handshake.
module top_fetch #(
   parameter int unsigned                DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]      RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_target,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready
);

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
   localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic                  discard_q, discard_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic                  instr_valid_q, instr_valid_d;
   logic [DATA_WIDTH-1:0] redirect_pc;

   assign redirect_pc = {redirect_target[DATA_WIDTH-1:2], 2'b00};

   // The request is a combinational pulse of ISSUE; reset masks it and pins the address.
   assign imem_req  = (state_q == ST_ISSUE) && !rst;
   assign imem_addr = rst ? RESET_PC : pc_q;

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
      state_d       = state_q;
      pc_d          = pc_q;
      discard_d     = discard_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;

      case (state_q)
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = ST_ISSUE;
               end else begin
                  instr_d       = imem_rdata;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = pc_q + PC_STEP;
                  state_d       = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = ST_ISSUE;
            end
         end
         default: state_d = ST_ISSUE;
      endcase

      // A redirect wins over everything above; a response still in flight must be dropped.
      if (redirect_valid) begin
         pc_d          = redirect_pc;
         instr_d       = instr_q;
         instr_pc_d    = instr_pc_q;
         instr_valid_d = 1'b0;
         case (state_q)
            ST_ISSUE: begin
               discard_d = 1'b1;
               state_d   = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  discard_d = 1'b0;
                  state_d   = ST_ISSUE;
               end else begin
                  discard_d = 1'b1;
                  state_d   = ST_WAIT;
               end
            end
            default: begin
               discard_d = 1'b0;
               state_d   = ST_ISSUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q       <= ST_ISSUE;
         pc_q          <= RESET_PC;
         discard_q     <= 1'b0;
         instr_q       <= NOP_INSTR;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         discard_q     <= discard_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

endmodule

// File: tb/tb_top_fetch.sv
// Bench for top_fetch: latency-randomised memory, expected PC stream scoreboard
// and directed redirect/reset/wrap scenarios.
module tb_top_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid = 1'b0;
   logic [31:0] w_rdata = '0;
   logic [31:0] w_instr;
   logic [31:0] w_instr_pc;
   logic        w_valid;

   always #5 clk = ~clk;

   top_fetch #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready)
   );

   top_fetch #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .redirect_valid(1'b0), .redirect_target(32'h0),
      .instr(w_instr), .instr_pc(w_instr_pc),
      .instr_valid(w_valid), .instr_ready(1'b1)
   );

   int checks = 0;
   int errors = 0;
   int accepted = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 | a;
   endfunction

   // Expected delivery stream: consecutive word addresses from the last restart point.
   logic [31:0] exp_q[$];

   task automatic restart_stream(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // Instruction memory for the main DUT: one request in flight, random latency.
   int          lat_min = 1;
   int          lat_max = 1;
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;

   initial forever begin
      @(negedge clk);
      if (imem_req) begin
         check("one_outstanding", 32'(pend), 32'd0);
         check("req_align", {30'b0, imem_addr[1:0]}, 32'd0);
         pend      = 1'b1;
         pend_addr = imem_addr;
         pend_cnt  = $urandom_range(lat_max, lat_min);
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
         end
      end
   end

   // Zero-wait memory and observers for the wrap-around instance.
   bit          w_pend = 1'b0;
   logic [31:0] w_pend_addr = '0;
   int          w_nreq = 0;
   logic [31:0] w_req_addr[2];
   bit          w_got = 1'b0;
   logic [31:0] w_first_pc = '0;
   logic [31:0] w_first_instr = '0;

   initial forever begin
      @(negedge clk);
      if (w_req) begin
         w_pend      = 1'b1;
         w_pend_addr = w_addr;
         if (w_nreq < 2) w_req_addr[w_nreq] = w_addr;
         w_nreq++;
      end
      if (!rst && w_valid && !w_got) begin
         w_got         = 1'b1;
         w_first_pc    = w_instr_pc;
         w_first_instr = w_instr;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      w_rvalid = w_pend;
      w_rdata  = w_pend ? mem_word(w_pend_addr) : $urandom;
      w_pend   = 1'b0;
   end

   // Monitor: scoreboard on every accepted handshake, plus hold-stability checks.
   bit          prev_hold = 1'b0;
   logic [31:0] prev_instr = '0;
   logic [31:0] prev_pc = '0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", instr, prev_instr);
            check("hold_pc", instr_pc, prev_pc);
         end
         if (instr_valid) check("hold_no_req", 32'(imem_req), 32'd0);
         if (instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               timeout_fail("sb_empty");
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               exp_q.push_back(exp_q[$] + 32'd4);
               accepted++;
               check("sb_pc", instr_pc, e);
               check("sb_instr", instr, mem_word(e));
            end
         end
         prev_hold  = instr_valid && !instr_ready && !redirect_valid;
         prev_instr = instr;
         prev_pc    = instr_pc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!imem_req && n < 40);
      if (!imem_req) timeout_fail(name);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!instr_valid && n < 40) begin
         step();
         n++;
      end
      if (!instr_valid) timeout_fail(name);
   endtask

   task automatic do_redirect(input logic [31:0] t);
      redirect_valid  = 1'b1;
      redirect_target = t;
      restart_stream({t[31:2], 2'b00});
      step();
      redirect_valid  = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      restart_stream(32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_pc", instr_pc, 32'h0);

      // Zero-wait memory, ready high: one instruction every third cycle.
      step();
      rst         = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("first_req", 32'(imem_req), 32'd1);
            check("first_addr", imem_addr, 32'h0);
         end
         check("thr_valid", 32'(instr_valid), 32'(i % 3 == 2));
         step();
      end

      // Stall with an instruction held for five cycles.
      instr_ready = 1'b0;
      wait_valid("stall_valid");
      repeat (5) begin
         @(negedge clk);
         step();
      end
      instr_ready = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      check("req_after_ready", 32'(imem_req), 32'd1);
      check("addr_after_ready", imem_addr, 32'h14);

      // Redirect while waiting on a slow response.
      lat_min = 3;
      lat_max = 3;
      repeat (6) step();
      wait_req("wait_req_a");
      step();
      do_redirect(32'h0000_0100);
      wait_req("redir_wait_req");
      check("redir_wait_addr", imem_addr, 32'h100);
      repeat (12) step();

      // Redirect in the same cycle the response returns.
      lat_min = 2;
      lat_max = 2;
      repeat (6) step();
      wait_req("wait_req_b");
      step();
      step();
      do_redirect(32'h0000_0300);
      @(negedge clk);
      check("redir_rv_req", 32'(imem_req), 32'd1);
      check("redir_rv_addr", imem_addr, 32'h300);
      check("redir_rv_valid", 32'(instr_valid), 32'd0);

      // Redirect while holding with ready high, then a misaligned target.
      lat_min = 1;
      lat_max = 1;
      step();
      wait_valid("hold_valid_a");
      do_redirect(32'h0000_0400);
      @(negedge clk);
      check("redir_hold_valid", 32'(instr_valid), 32'd0);
      check("redir_hold_req", 32'(imem_req), 32'd1);
      check("redir_hold_addr", imem_addr, 32'h400);
      step();
      wait_valid("hold_valid_b");
      do_redirect(32'h0000_0203);
      @(negedge clk);
      check("redir_align_addr", imem_addr, 32'h200);
      repeat (10) step();

      // Randomised traffic.
      lat_min = 1;
      lat_max = 4;
      for (int c = 0; c < 1500; c++) begin
         instr_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 99) < 3) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            redirect_valid  = 1'b1;
            redirect_target = t;
            restart_stream({t[31:2], 2'b00});
         end else begin
            redirect_valid = 1'b0;
         end
         step();
      end
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      repeat (20) step();

      // Reset during WAIT; the late response lands in ISSUE and must be ignored.
      lat_min = 3;
      lat_max = 3;
      repeat (6) step();
      wait_req("wait_req_c");
      step();
      rst = 1'b1;
      restart_stream(32'h0);
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_req", 32'(imem_req), 32'd1);
      check("post_rst_addr", imem_addr, 32'h0);
      check("post_rst_valid", 32'(instr_valid), 32'd0);
      step();
      @(negedge clk);
      check("late_rv_ignored", 32'(instr_valid), 32'd0);
      lat_min = 1;
      lat_max = 1;
      repeat (12) step();

      check("accepted_enough", 32'(accepted >= 50), 32'd1);
      check("wrap_nreq", 32'(w_nreq >= 2), 32'd1);
      check("wrap_addr0", w_req_addr[0], 32'hFFFF_FFFC);
      check("wrap_addr1", w_req_addr[1], 32'h0);
      check("wrap_first_pc", w_first_pc, 32'hFFFF_FFFC);
      check("wrap_first_instr", w_first_instr, mem_word(32'hFFFF_FFFC));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/top_fetch.md
# top_fetch

Instruction fetch stage that produces the 32-bit `instr` word consumed by `top_decode`. It owns the program counter and issues single-outstanding read requests to instruction memory. It registers each returned word together with its PC and presents it to decode over a valid/ready handshake. Redirects from the branch/jump path flush in-flight work and restart fetch at the new target.

## Interface
- `DATA_WIDTH`, 32, width of instruction, address and PC.
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request, single-cycle pulse.
- `imem_addr`  out  DATA_WIDTH  byte address of the request; bits [1:0] always 0.
- `imem_rvalid`  in  1  read data valid, one cycle per request.
- `imem_rdata`  in  DATA_WIDTH  returned instruction word.
- `redirect_valid`  in  1  taken branch/jump; highest priority.
- `redirect_target`  in  DATA_WIDTH  new PC; bits [1:0] ignored and forced to 0.
- `instr`  out  DATA_WIDTH  instruction to decode.
- `instr_pc`  out  DATA_WIDTH  PC of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.

## Operation
- Registers: `pc`, `state`, `discard` flag, output registers `instr`, `instr_pc`, `instr_valid`.
- State `ISSUE`:
  - `imem_req`=1, `imem_addr`=`pc`; both are combinational from state and `pc`.
  - Next state is `WAIT`.
- State `WAIT`:
  - `imem_req`=0; waits for `imem_rvalid`.
  - On `imem_rvalid` with `discard`=0: `instr`<=`imem_rdata`, `instr_pc`<=`pc`, `instr_valid`<=1, `pc`<=`pc`+4, next state `HOLD`.
  - On `imem_rvalid` with `discard`=1: drop the data, clear `discard`, next state `ISSUE`.
- State `HOLD`:
  - `instr_valid`=1; `instr` and `instr_pc` are stable.
  - On `instr_ready`: `instr_valid`<=0, next state `ISSUE`.
- Redirect (`redirect_valid`=1) overrides all of the above in the same cycle:
  - `pc`<={target[31:2],2'b00}; `instr_valid`<=0, so a held instruction is dropped even if `instr_ready`=1.
  - From `ISSUE`: the request issued this cycle still goes out with the old `pc`. Set `discard`, go to `WAIT`.
  - From `WAIT` with no `imem_rvalid`: set `discard`, stay in `WAIT`.
  - From `WAIT` with `imem_rvalid` in the same cycle: drop the data, leave `discard`=0, go to `ISSUE`.
  - From `HOLD`: go to `ISSUE`.
- `imem_rvalid` outside `WAIT` is ignored.
- PC arithmetic is modulo 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values while `rst`=1:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `pc`=RESET_PC, `state`=`ISSUE`, `discard`=0.
  - `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=0.
- First `imem_req` occurs in the first cycle with `rst`=0.
- Request in cycle N; `imem_rvalid` arrives at N+1 or later.
- `instr_valid` rises the cycle after the accepted `imem_rvalid`.
- Back-to-back throughput with zero-wait memory and `instr_ready` held at 1: one instruction per 3 cycles (ISSUE, WAIT, HOLD).
- At most one request is outstanding at any time.
- `instr` and `instr_pc` must not change while `instr_valid`=1 and `instr_ready`=0.
- Asserting `rst` mid-operation abandons any outstanding request. A late `imem_rvalid` arriving in `ISSUE` after reset is ignored.

## Test plan
- Reset, memory returns word = 32'h1000_0000 | addr with one-cycle latency, `instr_ready`=1 -> `instr_pc` sequence 0, 4, 8, 12 with matching `instr`; `instr_valid` high every 3rd cycle.
- Hold `instr_ready`=0 for 5 cycles with an instruction held -> `instr` and `instr_pc` stable, no `imem_req` issued; request issues 1 cycle after ready rises.
- Redirect to 32'h0000_0100 while in `WAIT` with 3-cycle memory latency -> stale response dropped; next `imem_addr`=0x100; next `instr_pc`=0x100.
- Redirect in the same cycle as `imem_rvalid`, and separately in `HOLD` with `instr_ready`=1 -> no `instr_valid` for the old instruction; the fetch at the target follows.
- `redirect_target`=32'h0000_0203 -> `imem_addr`=0x200. Also start with RESET_PC=32'hFFFF_FFFC -> second fetch address is 0.
- Assert `rst` during `WAIT`, then send a late `imem_rvalid` -> ignored; `instr_valid`=0; fresh request at RESET_PC.
